ht_req_arbiter: RTL and testbench

- Shares one hash-table pipeline (command channel, result channel, clear controls) among NUM_REQ requesters.
- Round-robin arbitration on the command side.
- Tracks in-flight requester IDs in an ID FIFO; the table returns results in command order, so results are steered back by FIFO head.
- Sequences table clear: block new commands, drain in-flight, run head- and data-table clears in parallel, report done.

---
 rtl/ht_req_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_ht_req_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ht_req_arbiter.sv
// Round-robin command arbiter and in-order result steering for a shared hash table.
// Optional HT_ARB_PERF_EN adds command and stall performance counters.
module ht_req_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int KEY_WIDTH    = 32,
    parameter int VALUE_WIDTH  = 32,
    parameter int MAX_INFLIGHT = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*KEY_WIDTH-1:0]   req_key_i,
    input  logic [NUM_REQ*VALUE_WIDTH-1:0] req_value_i,
    input  logic [NUM_REQ*2-1:0]           req_opcode_i,
    output logic [NUM_REQ-1:0]             rsp_valid_o,
    input  logic [NUM_REQ-1:0]             rsp_ready_i,
    output logic                           ht_cmd_valid_o,
    input  logic                           ht_cmd_ready_i,
    output logic [KEY_WIDTH-1:0]           ht_cmd_key_o,
    output logic [VALUE_WIDTH-1:0]         ht_cmd_value_o,
    output logic [1:0]                     ht_cmd_opcode_o,
    input  logic                           ht_res_valid_i,
    output logic                           ht_res_ready_o,
    input  logic                           clear_req_i,
    output logic                           clear_done_o,
    output logic                           busy_o,
    output logic                           ht_clear_ram_run_o,
    input  logic                           ht_clear_ram_done_i,
    output logic                           dt_clear_ram_run_o,
    input  logic                           dt_clear_ram_done_i
`ifdef HT_ARB_PERF_EN
    ,
    output logic [31:0]                    perf_cmd_cnt_o,
    output logic [31:0]                    perf_stall_cnt_o
`endif
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AW = $clog2(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IW-1:0]     r_rr;
    logic [IW-1:0]     r_fifo [MAX_INFLIGHT];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_ht_done;
    logic              r_dt_done;
    logic              r_run_sent;

    logic              w_empty;
    logic              w_full;
    logic              w_elig;
    logic              w_any;
    logic [IW-1:0]     w_gidx;
    logic [NUM_REQ-1:0] w_grant;
    logic [IW-1:0]     w_head;
    logic              w_push;
    logic              w_pop;
    logic              w_ht_seen;
    logic              w_dt_seen;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base,
                                               input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IW'(s);
    endfunction

    assign w_empty = (r_count == '0);
    // full comes from the registered count, so a same-cycle pop never frees a slot early
    assign w_full  = (r_count == (AW+1)'(MAX_INFLIGHT));
    assign w_elig  = rst_ni && (r_state == S_IDLE) && !w_full;

    always_comb begin
        w_any  = 1'b0;
        w_gidx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_any && req_valid_i[wrap_idx(r_rr, k)]) begin
                w_any  = 1'b1;
                w_gidx = wrap_idx(r_rr, k);
            end
        end
        if (!w_elig) w_any = 1'b0;
        w_grant = w_any ? (NUM_REQ'(1) << w_gidx) : '0;
    end

    always_comb begin
        ht_cmd_key_o    = '0;
        ht_cmd_value_o  = '0;
        ht_cmd_opcode_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                ht_cmd_key_o    = req_key_i[i*KEY_WIDTH +: KEY_WIDTH];
                ht_cmd_value_o  = req_value_i[i*VALUE_WIDTH +: VALUE_WIDTH];
                ht_cmd_opcode_o = req_opcode_i[i*2 +: 2];
            end
        end
    end

    assign ht_cmd_valid_o = w_any;
    assign req_ready_o    = ht_cmd_ready_i ? w_grant : '0;
    assign w_push         = w_any && ht_cmd_ready_i;

    assign w_head         = r_fifo[r_rd_ptr];
    assign ht_res_ready_o = !w_empty && rsp_ready_i[w_head];
    assign rsp_valid_o    = (ht_res_valid_i && !w_empty) ?
                            (NUM_REQ'(1) << w_head) : '0;
    assign w_pop          = ht_res_valid_i && ht_res_ready_o;

    assign busy_o = (r_state != S_IDLE) || !w_empty;

    always_ff @(posedge clk_i) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_gidx;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rr     <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_rr     <= (w_gidx == IW'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop) r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    assign w_ht_seen = r_ht_done || ht_clear_ram_done_i;
    assign w_dt_seen = r_dt_done || dt_clear_ram_done_i;

    always_comb begin
        w_state_nxt        = r_state;
        clear_done_o       = 1'b0;
        ht_clear_ram_run_o = 1'b0;
        dt_clear_ram_run_o = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (clear_req_i) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_empty) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                ht_clear_ram_run_o = !r_run_sent;
                dt_clear_ram_run_o = !r_run_sent;
                if (w_ht_seen && w_dt_seen) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                clear_done_o = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_ht_done  <= 1'b0;
            r_dt_done  <= 1'b0;
            r_run_sent <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_CLEAR) begin
                r_run_sent <= 1'b1;
                r_ht_done  <= w_ht_seen;
                r_dt_done  <= w_dt_seen;
            end else if (r_state == S_DONE) begin
                r_run_sent <= 1'b0;
                r_ht_done  <= 1'b0;
                r_dt_done  <= 1'b0;
            end
        end
    end

`ifdef HT_ARB_PERF_EN
    logic w_clr_entry;
    assign w_clr_entry = (w_state_nxt == S_CLEAR) && (r_state != S_CLEAR);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cmd_cnt_o   <= '0;
            perf_stall_cnt_o <= '0;
        end else if (w_clr_entry) begin
            perf_cmd_cnt_o   <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            if (w_push) perf_cmd_cnt_o <= perf_cmd_cnt_o + 32'd1;
            if (|req_valid_i && !w_push)
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ht_req_arbiter.sv
// Scoreboard bench for ht_req_arbiter: arbitration, steering, FIFO full, clear, reset.
module tb_ht_req_arbiter;
    localparam int N     = 4;
    localparam int KW    = 32;
    localparam int VW    = 32;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*KW-1:0] req_key = '0;
    logic [N*VW-1:0] req_value = '0;
    logic [N*2-1:0]  req_opcode = '0;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '0;
    logic            cmd_valid;
    logic            cmd_ready = 1'b0;
    logic [KW-1:0]   cmd_key;
    logic [VW-1:0]   cmd_value;
    logic [1:0]      cmd_opcode;
    logic            res_valid = 1'b0;
    logic            res_ready;
    logic            clear_req = 1'b0;
    logic            clear_done;
    logic            busy;
    logic            ht_run;
    logic            ht_done = 1'b0;
    logic            dt_run;
    logic            dt_done = 1'b0;

    int errors = 0;
    int checks = 0;
    int run_cnt = 0;
    int sb[$];

    ht_req_arbiter #(
        .NUM_REQ(N), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .MAX_INFLIGHT(DEPTH)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_key_i(req_key), .req_value_i(req_value), .req_opcode_i(req_opcode),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .ht_cmd_valid_o(cmd_valid), .ht_cmd_ready_i(cmd_ready),
        .ht_cmd_key_o(cmd_key), .ht_cmd_value_o(cmd_value),
        .ht_cmd_opcode_o(cmd_opcode),
        .ht_res_valid_i(res_valid), .ht_res_ready_o(res_ready),
        .clear_req_i(clear_req), .clear_done_o(clear_done), .busy_o(busy),
        .ht_clear_ram_run_o(ht_run), .ht_clear_ram_done_i(ht_done),
        .dt_clear_ram_run_o(dt_run), .dt_clear_ram_done_i(dt_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ht_run) run_cnt++;

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [KW-1:0] key_of(input int i);
        return 32'hC0DE_0000 + KW'(i);
    endfunction

    function automatic logic [VW-1:0] val_of(input int i);
        return 32'h5A00_0000 + VW'(i * 3);
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic ngt();
        @(negedge clk);
    endtask

    task automatic drain_results();
        int id;
        res_valid = 1'b1;
        rsp_ready = '1;
        while (sb.size() > 0) begin
            ngt();
            id = sb.pop_front();
            checks++;
            if ({rsp_valid, res_ready} !== {4'(1 << id), 1'b1}) begin
                errors++;
                $display("FAIL drain rsp_valid=%b res_ready=%b exp_id=%0d",
                         rsp_valid, res_ready, id);
            end
            nxt();
        end
        res_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) ngt();
        checks++;
        if ({busy, cmd_valid, res_ready, clear_done, ht_run, dt_run,
             req_ready, rsp_valid} !== '0) begin
            errors++;
            $display("FAIL reset_outs busy=%b cmd_valid=%b req_ready=%b",
                     busy, cmd_valid, req_ready);
        end
        nxt();
        rst_n = 1'b1;
        ngt();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release busy got=%b exp=0", busy);
        end
        nxt();
    endtask

    task automatic test_round_robin();
        int exp_id = 0;
        req_valid = '1;
        cmd_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            ngt();
            checks++;
            if ({req_ready, cmd_key, cmd_value, cmd_opcode} !==
                {4'(1 << exp_id), key_of(exp_id), val_of(exp_id), 2'(exp_id)}) begin
                errors++;
                $display("FAIL rr_grant cycle=%0d req_ready=%b key=%h exp_id=%0d",
                         c, req_ready, cmd_key, exp_id);
            end
            sb.push_back(exp_id);
            exp_id = (exp_id + 1) % N;
            nxt();
        end
        req_valid = '0;
        drain_results();
    endtask

    task automatic test_backpressure();
        req_valid = 4'b0100;
        cmd_ready = 1'b0;
        repeat (5) begin
            ngt();
            checks++;
            if ({cmd_valid, req_ready, cmd_key, busy} !==
                {1'b1, 4'b0000, key_of(2), 1'b0}) begin
                errors++;
                $display("FAIL bp_hold cmd_valid=%b req_ready=%b key=%h busy=%b",
                         cmd_valid, req_ready, cmd_key, busy);
            end
            nxt();
        end
        cmd_ready = 1'b1;
        ngt();
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_release req_ready got=%b exp=0100", req_ready);
        end
        sb.push_back(2);
        nxt();
        req_valid = '0;
        ngt();
        checks++;
        if ({busy, cmd_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_one_push busy=%b cmd_valid=%b exp=1,0", busy, cmd_valid);
        end
        nxt();
        drain_results();
    endtask

    task automatic test_steering();
        int ids[3] = '{1, 3, 1};
        cmd_ready = 1'b1;
        foreach (ids[k]) begin
            req_valid = 4'(1 << ids[k]);
            ngt();
            checks++;
            if (req_ready !== 4'(1 << ids[k])) begin
                errors++;
                $display("FAIL steer_issue req_ready=%b exp_id=%0d", req_ready, ids[k]);
            end
            sb.push_back(ids[k]);
            nxt();
        end
        req_valid = '0;
        res_valid = 1'b1;
        rsp_ready = '1;
        ngt();
        checks++;
        if ({rsp_valid, res_ready} !== {4'(1 << sb[0]), 1'b1}) begin
            errors++;
            $display("FAIL steer_first rsp_valid=%b res_ready=%b", rsp_valid, res_ready);
        end
        void'(sb.pop_front());
        nxt();
        rsp_ready = 4'b0111;
        repeat (2) begin
            ngt();
            checks++;
            if ({rsp_valid, res_ready} !== {4'(1 << sb[0]), 1'b0}) begin
                errors++;
                $display("FAIL steer_stall rsp_valid=%b res_ready=%b exp=1000,0",
                         rsp_valid, res_ready);
            end
            nxt();
        end
        drain_results();
    endtask

    task automatic test_fifo_full();
        req_valid = 4'b0001;
        cmd_ready = 1'b1;
        for (int c = 0; c < DEPTH; c++) begin
            ngt();
            checks++;
            if ({cmd_valid, req_ready} !== {1'b1, 4'b0001}) begin
                errors++;
                $display("FAIL full_fill c=%0d cmd_valid=%b req_ready=%b",
                         c, cmd_valid, req_ready);
            end
            sb.push_back(0);
            nxt();
        end
        ngt();
        checks++;
        if ({cmd_valid, req_ready} !== {1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL full_block cmd_valid=%b req_ready=%b", cmd_valid, req_ready);
        end
        nxt();
        res_valid = 1'b1;
        rsp_ready = '1;
        ngt();
        checks++;
        if ({cmd_valid, res_ready} !== 2'b01) begin
            errors++;
            $display("FAIL full_pop_cycle cmd_valid=%b res_ready=%b exp=0,1",
                     cmd_valid, res_ready);
        end
        void'(sb.pop_front());
        nxt();
        res_valid = 1'b0;
        ngt();
        checks++;
        if ({cmd_valid, req_ready} !== {1'b1, 4'b0001}) begin
            errors++;
            $display("FAIL full_resume cmd_valid=%b req_ready=%b", cmd_valid, req_ready);
        end
        sb.push_back(0);
        nxt();
        req_valid = '0;
        drain_results();
    endtask

    task automatic test_clear();
        int run0;
        bit found = 0;
        bit dt_seen = 0;
        cmd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid = 4'(1 << i);
            sb.push_back(i);
            nxt();
        end
        req_valid = '0;
        clear_req = 1'b1;
        nxt();
        clear_req = 1'b0;
        req_valid = 4'b1000;
        repeat (2) begin
            ngt();
            checks++;
            if ({cmd_valid, req_ready, busy} !== {1'b0, 4'b0000, 1'b1}) begin
                errors++;
                $display("FAIL clr_block cmd_valid=%b req_ready=%b busy=%b",
                         cmd_valid, req_ready, busy);
            end
            nxt();
        end
        req_valid = '0;
        run0 = run_cnt;
        drain_results();
        for (int k = 0; k < 10 && !found; k++) begin
            ngt();
            if (ht_run) begin
                found = 1;
                dt_seen = dt_run;
            end
            nxt();
        end
        checks++;
        if ({found, dt_seen} !== 2'b11) begin
            errors++;
            $display("FAIL clr_run found=%b dt_run=%b exp=1,1", found, dt_seen);
        end
        for (int k = 0; k < 10; k++) begin
            dt_done = (k == 0);
            ht_done = (k == 7);
            ngt();
            checks++;
            if ({clear_done, busy} !== {(k == 8), (k <= 8)}) begin
                errors++;
                $display("FAIL clr_done k=%0d clear_done=%b busy=%b", k, clear_done, busy);
            end
            nxt();
        end
        dt_done = 1'b0;
        ht_done = 1'b0;
        checks++;
        if (run_cnt - run0 !== 1) begin
            errors++;
            $display("FAIL clr_run_count got=%0d exp=1", run_cnt - run0);
        end
    endtask

    task automatic test_reset_mid_clear();
        int run0;
        bit found = 0;
        clear_req = 1'b1;
        nxt();
        clear_req = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            ngt();
            found = ht_run;
            nxt();
        end
        checks++;
        if ({found, busy} !== 2'b11) begin
            errors++;
            $display("FAIL rmc_enter_clear found=%b busy=%b", found, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, cmd_valid, res_ready, clear_done, ht_run, dt_run,
             req_ready, rsp_valid} !== '0) begin
            errors++;
            $display("FAIL rmc_outs busy=%b run=%b%b clear_done=%b",
                     busy, ht_run, dt_run, clear_done);
        end
        ngt();
        rst_n = 1'b1;
        run0 = run_cnt;
        nxt();
        res_valid = 1'b1;
        rsp_ready = '1;
        ngt();
        checks++;
        if ({rsp_valid, res_ready, busy} !== '0) begin
            errors++;
            $display("FAIL rmc_empty_res rsp_valid=%b res_ready=%b busy=%b",
                     rsp_valid, res_ready, busy);
        end
        nxt();
        res_valid = 1'b0;
        repeat (4) nxt();
        checks++;
        if (run_cnt !== run0) begin
            errors++;
            $display("FAIL rmc_spurious_run got=%0d exp=%0d", run_cnt, run0);
        end
        req_valid = '1;
        ngt();
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rmc_ptr_reset req_ready got=%b exp=0001", req_ready);
        end
        nxt();
        req_valid = '0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            req_key[i*KW +: KW]   = key_of(i);
            req_value[i*VW +: VW] = val_of(i);
            req_opcode[i*2 +: 2]  = 2'(i);
        end
        test_reset();
        test_round_robin();
        test_backpressure();
        test_steering();
        test_fifo_full();
        test_clear();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
